// File: rtl/router_pkg.sv
// Shared constants, helper function and storage-word type for the router egress FIFO.
package router_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int LEN_LSB_DEF  = 2;
    // Header byte layout: {payload length, destination address}
    localparam int ADDR_FIELD_W = LEN_LSB_DEF;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    typedef struct packed {
        logic                  hdr;
        logic [DATA_W_DEF-1:0] data;
    } fifo_word_t;

endpackage

// File: rtl/router_fifo_mem.sv
// Simple dual-port register array: one write port, one registered read port
// plus a combinational view of the word at the read address.
module router_fifo_mem #(
    parameter int WORD_W = 9,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [WORD_W-1:0] rd_peek,
    output logic [WORD_W-1:0] rd_data
);

    logic [WORD_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_peek = mem[rd_addr];

    // The array itself is never cleared; only the output register is.
    always_ff @(posedge clock) begin
        if (clear) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= rd_peek;
        end
    end

endmodule

// File: rtl/router_pkt_fifo.sv
// Packet-aware egress FIFO: stores a header flag per word and tracks how many
// payload/parity bytes of the current packet are still to be read.
module router_pkt_fifo
    import router_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int LEN_LSB  = LEN_LSB_DEF
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   soft_reset,
    input  logic                   write_en,
    input  logic                   hdr_in,
    input  logic [DATA_W-1:0]      data_in,
    input  logic                   read_en,
    output logic [DATA_W-1:0]      data_out,
    output logic                   hdr_out,
    output logic                   rd_valid,
    output logic                   pkt_busy,
    output logic                   full,
    output logic                   empty,
    output logic                   almost_full,
    output logic                   almost_empty,
    output logic [clog2(DEPTH):0]  count,
    output logic                   overflow,
    output logic                   underflow
);

    localparam int AW      = clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int FIELD_W = DATA_W - LEN_LSB;
    localparam int LEN_W   = FIELD_W + 1;
    localparam logic [CW-1:0] AF_THRESH = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_THRESH = CW'(AE_LEVEL);

    typedef struct packed {
        logic              hdr;
        logic [DATA_W-1:0] data;
    } word_t;

    logic [CW-1:0]    wr_ptr;
    logic [CW-1:0]    rd_ptr;
    logic             flush;
    logic             do_write;
    logic             do_read;
    word_t            wr_word;
    word_t            rd_word;
    word_t            peek_word;
    logic [LEN_W-1:0] pkt_cnt;
    logic [LEN_W-1:0] pkt_cnt_next;

    assign flush = !resetn || soft_reset;

    // Pointers carry an extra wrap bit so full and empty are distinguishable.
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign empty        = (wr_ptr == rd_ptr);
    assign count        = wr_ptr - rd_ptr;
    assign almost_full  = (count >= AF_THRESH);
    assign almost_empty = (count <= AE_THRESH);

    assign do_write = write_en && !full && !flush;
    assign do_read  = read_en && !empty && !flush;

    assign wr_word  = '{hdr: hdr_in, data: data_in};
    assign data_out = rd_word.data;
    assign hdr_out  = rd_word.hdr;

    router_fifo_mem #(
        .WORD_W (DATA_W + 1),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clock   (clock),
        .clear   (flush),
        .wr_en   (do_write),
        .wr_addr (wr_ptr[AW-1:0]),
        .wr_data (wr_word),
        .rd_en   (do_read),
        .rd_addr (rd_ptr[AW-1:0]),
        .rd_peek (peek_word),
        .rd_data (rd_word)
    );

    // A header reload always wins, so a truncated packet is silently replaced.
    always_comb begin
        pkt_cnt_next = pkt_cnt;
        if (do_read) begin
            if (peek_word.hdr) begin
                pkt_cnt_next = {1'b0, peek_word.data[DATA_W-1:LEN_LSB]} + LEN_W'(1);
            end else if (pkt_cnt != '0) begin
                pkt_cnt_next = pkt_cnt - LEN_W'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            pkt_cnt   <= '0;
            pkt_busy  <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + CW'(1);
            end
            if (do_read) begin
                rd_ptr <= rd_ptr + CW'(1);
            end
            rd_valid  <= do_read;
            overflow  <= write_en && full;
            underflow <= read_en && empty;
            pkt_cnt   <= pkt_cnt_next;
            pkt_busy  <= (pkt_cnt_next != '0);
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Directed bench for router_pkt_fifo: reset, fill/drain, simultaneous access,
// packet tracking, pointer wrap and soft flush, checked with immediate assertions.
module tb_router_pkt_fifo;
    import router_pkg::*;

    logic       clock;
    logic       resetn;
    logic       soft_reset;
    logic       write_en;
    logic       hdr_in;
    logic [7:0] data_in;
    logic       read_en;
    logic [7:0] data_out;
    logic       hdr_out;
    logic       rd_valid;
    logic       pkt_busy;
    logic       full;
    logic       empty;
    logic       almost_full;
    logic       almost_empty;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int tests;
    int failures;

    router_pkt_fifo #(
        .DATA_W   (8),
        .DEPTH    (16),
        .AF_LEVEL (14),
        .AE_LEVEL (2),
        .LEN_LSB  (2)
    ) dut (
        .clock        (clock),
        .resetn       (resetn),
        .soft_reset   (soft_reset),
        .write_en     (write_en),
        .hdr_in       (hdr_in),
        .data_in      (data_in),
        .read_en      (read_en),
        .data_out     (data_out),
        .hdr_out      (hdr_out),
        .rd_valid     (rd_valid),
        .pkt_busy     (pkt_busy),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock with the given requests; returns 1 time unit after the edge.
    task automatic applyStimulus(input logic w, input logic h, input logic [7:0] d,
                                 input logic r);
        write_en = w;
        hdr_in   = h;
        data_in  = d;
        read_en  = r;
        @(posedge clock);
        #1;
        write_en = 1'b0;
        read_en  = 1'b0;
        hdr_in   = 1'b0;
    endtask

    initial begin
        fifo_word_t word;
        logic [7:0] v;
        tests      = 0;
        failures   = 0;
        resetn     = 1'b0;
        soft_reset = 1'b0;
        write_en   = 1'b0;
        hdr_in     = 1'b0;
        data_in    = 8'h00;
        read_en    = 1'b0;

        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset data_out", data_out, 8'h00);
        checkOutput("reset empty", empty, 1'b1);
        checkOutput("reset full", full, 1'b0);
        checkOutput("reset count", count, 5'd0);
        checkOutput("reset almost_empty", almost_empty, 1'b1);
        checkOutput("reset almost_full", almost_full, 1'b0);
        checkOutput("reset rd_valid", rd_valid, 1'b0);
        checkOutput("reset pkt_busy", pkt_busy, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        checkOutput("reset underflow", underflow, 1'b0);
        resetn = 1'b1;

        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(i), 1'b0);
            checkOutput("fill count", count, 32'(i));
            checkOutput("fill almost_full", almost_full, (i >= 14) ? 1'b1 : 1'b0);
            checkOutput("fill almost_empty", almost_empty, (i <= 2) ? 1'b1 : 1'b0);
        end
        checkOutput("full flag", full, 1'b1);
        checkOutput("full not empty", empty, 1'b0);

        applyStimulus(1'b1, 1'b0, 8'hFF, 1'b0);
        checkOutput("overflow pulse", overflow, 1'b1);
        checkOutput("overflow count", count, 5'd16);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("overflow single", overflow, 1'b0);

        applyStimulus(1'b1, 1'b0, 8'hEE, 1'b1);
        checkOutput("rw full count", count, 5'd15);
        checkOutput("rw full data", data_out, 8'h01);
        checkOutput("rw full rd_valid", rd_valid, 1'b1);
        checkOutput("rw full overflow", overflow, 1'b1);

        for (int i = 2; i <= 16; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("drain data", data_out, 32'(i));
            checkOutput("drain rd_valid", rd_valid, 1'b1);
            checkOutput("drain count", count, 32'(16 - i));
        end
        checkOutput("drained empty", empty, 1'b1);

        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("underflow pulse", underflow, 1'b1);
        checkOutput("underflow rd_valid", rd_valid, 1'b0);
        checkOutput("underflow hold", data_out, 8'h10);

        applyStimulus(1'b1, 1'b0, 8'h33, 1'b1);
        checkOutput("rw empty count", count, 5'd1);
        checkOutput("rw empty underflow", underflow, 1'b1);
        checkOutput("rw empty hold", data_out, 8'h10);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("rw empty data", data_out, 8'h33);
        checkOutput("rw empty underflow clr", underflow, 1'b0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h41 + i), 1'b0);
        end
        applyStimulus(1'b1, 1'b0, 8'h46, 1'b1);
        checkOutput("rw mid count", count, 5'd5);
        checkOutput("rw mid data", data_out, 8'h41);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("rw mid drain", data_out, 32'(8'h42 + i));
        end
        checkOutput("rw mid empty", empty, 1'b1);

        // Header 0x0D: len 3 -> 4 bytes follow (payload + parity).
        applyStimulus(1'b1, 1'b1, 8'h0D, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'hB1 + i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        word = '{hdr: hdr_out, data: data_out};
        checkOutput("pkt header word", word, 9'h10D);
        checkOutput("pkt busy hdr", pkt_busy, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("pkt byte", data_out, 32'(8'hB1 + i));
            checkOutput("pkt byte hdr_out", hdr_out, 1'b0);
            checkOutput("pkt busy", pkt_busy, (i < 3) ? 1'b1 : 1'b0);
        end

        applyStimulus(1'b1, 1'b1, 8'h03, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'h99, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("len0 busy hdr", pkt_busy, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("len0 busy parity", pkt_busy, 1'b0);

        // Truncated packet: second header (len 2) reloads the counter to 3.
        applyStimulus(1'b1, 1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hC1, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h09, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hC2, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hC3, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hC4, 1'b0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("trunc busy", pkt_busy, (i < 5) ? 1'b1 : 1'b0);
        end
        checkOutput("trunc last data", data_out, 8'hC4);

        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h60 + i), 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'h63 + k), 1'b1);
            v = 8'(8'h60 + k);
            checkOutput("wrap data", data_out, v);
            checkOutput("wrap count", count, 5'd3);
            checkOutput("wrap full", full, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("wrap drain", data_out, 32'(8'h88 + i));
        end
        checkOutput("wrap empty", empty, 1'b1);

        // Header 0x1D: len 7 -> 8 bytes; flush after the header is read.
        applyStimulus(1'b1, 1'b1, 8'h1D, 1'b0);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, 1'b0, 8'(8'hC1 + i), 1'b0);
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("pre flush count", count, 5'd7);
        checkOutput("pre flush busy", pkt_busy, 1'b1);
        soft_reset = 1'b1;
        applyStimulus(1'b1, 1'b0, 8'h77, 1'b1);
        soft_reset = 1'b0;
        checkOutput("flush count", count, 5'd0);
        checkOutput("flush empty", empty, 1'b1);
        checkOutput("flush busy", pkt_busy, 1'b0);
        checkOutput("flush data_out", data_out, 8'h00);
        checkOutput("flush rd_valid", rd_valid, 1'b0);
        applyStimulus(1'b1, 1'b0, 8'hA5, 1'b0);
        checkOutput("post flush count", count, 5'd1);
        applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("post flush data", data_out, 8'hA5);
        checkOutput("post flush rd_valid", rd_valid, 1'b1);

        applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
        resetn = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h22, 1'b1);
        resetn = 1'b1;
        checkOutput("midop reset count", count, 5'd0);
        checkOutput("midop reset data", data_out, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
